// File: rtl/obi_bank_arbiter.sv
// obi_bank_arbiter: round-robin arbiter letting NMASTERS OBI requesters share one RAM bank.
// Ports:
//   clk_i, rst_ni                 clock, synchronous active-low reset
//   m_req_i / m_gnt_o             per-master request / combinational grant
//   m_addr_i, m_we_i, m_be_i,     packed per-master request fields (master i at [i*W +: W])
//   m_wdata_i
//   m_rvalid_o, m_rdata_o         per-master response valid, broadcast response data
//   s_req_o, s_gnt_i, s_addr_o,   bank request channel carrying the winner's fields
//   s_we_o, s_be_o, s_wdata_o
//   s_rvalid_i, s_rdata_i         bank response channel (in order)
//   busy_o                        outstanding count is nonzero
//   err_o                         sticky protocol error (dropped locked request, spurious response)
module obi_bank_arbiter #(
    parameter int NMASTERS = 3,
    parameter int AW       = 32,
    parameter int DW       = 32,
    parameter int DEPTH    = 2
) (
    input  logic                   clk_i,
    input  logic                   rst_ni,
    input  logic [NMASTERS-1:0]    m_req_i,
    output logic [NMASTERS-1:0]    m_gnt_o,
    input  logic [NMASTERS*AW-1:0] m_addr_i,
    input  logic [NMASTERS-1:0]    m_we_i,
    input  logic [NMASTERS*DW/8-1:0] m_be_i,
    input  logic [NMASTERS*DW-1:0] m_wdata_i,
    output logic [NMASTERS-1:0]    m_rvalid_o,
    output logic [DW-1:0]          m_rdata_o,
    output logic                   s_req_o,
    input  logic                   s_gnt_i,
    output logic [AW-1:0]          s_addr_o,
    output logic                   s_we_o,
    output logic [DW/8-1:0]        s_be_o,
    output logic [DW-1:0]          s_wdata_o,
    input  logic                   s_rvalid_i,
    input  logic [DW-1:0]          s_rdata_i,
    output logic                   busy_o,
    output logic                   err_o
);
    localparam int IW = NMASTERS > 1 ? $clog2(NMASTERS) : 1;
    localparam int PW = DEPTH > 1 ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);
    localparam int BW = DW / 8;

    logic [IW-1:0] r_rr, r_lock_idx, w_scan_idx, w_win;
    logic [IW-1:0] r_fifo [DEPTH];
    logic [PW-1:0] r_wp, r_rp;
    logic [CW-1:0] r_cnt, w_cnt_n;
    logic          r_lock, r_busy, r_err;
    logic          w_scan_found, w_found, w_sreq, w_hs, w_pop, w_spur, w_drop;

    // Scan downward from the farthest offset so the requester closest to r_rr is written last and wins.
    always_comb begin
        w_scan_found = 1'b0;
        w_scan_idx   = '0;
        for (int k = NMASTERS - 1; k >= 0; k--) begin
            if (m_req_i[(int'(r_rr) + k) % NMASTERS]) begin
                w_scan_found = 1'b1;
                w_scan_idx   = IW'((int'(r_rr) + k) % NMASTERS);
            end
        end
    end

    // A stalled request pins the winner so the bank sees stable fields until it grants.
    assign w_win   = r_lock ? r_lock_idx : w_scan_idx;
    assign w_found = r_lock ? m_req_i[r_lock_idx] : w_scan_found;
    assign w_drop  = r_lock && !m_req_i[r_lock_idx];
    assign w_sreq  = rst_ni && w_found && (r_cnt < CW'(DEPTH));
    assign w_hs    = w_sreq && s_gnt_i;
    assign w_pop   = rst_ni && s_rvalid_i && (r_cnt != '0);
    assign w_spur  = s_rvalid_i && (r_cnt == '0);
    assign w_cnt_n = r_cnt + CW'(w_hs) - CW'(w_pop);

    assign s_req_o    = w_sreq;
    assign s_addr_o   = w_sreq ? m_addr_i[w_win*AW +: AW] : '0;
    assign s_we_o     = w_sreq ? m_we_i[w_win] : 1'b0;
    assign s_be_o     = w_sreq ? m_be_i[w_win*BW +: BW] : '0;
    assign s_wdata_o  = w_sreq ? m_wdata_i[w_win*DW +: DW] : '0;
    assign m_gnt_o    = w_hs ? (NMASTERS'(1) << w_win) : '0;
    assign m_rvalid_o = w_pop ? (NMASTERS'(1) << r_fifo[r_rp]) : '0;
    assign m_rdata_o  = s_rdata_i;
    assign busy_o     = r_busy;
    assign err_o      = r_err;

    always_ff @(posedge clk_i) begin
        if (w_hs) r_fifo[r_wp] <= w_win;
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            r_rr       <= '0;
            r_cnt      <= '0;
            r_wp       <= '0;
            r_rp       <= '0;
            r_lock     <= 1'b0;
            r_lock_idx <= '0;
            r_busy     <= 1'b0;
            r_err      <= 1'b0;
        end else begin
            if (w_hs) begin
                r_wp <= (r_wp == PW'(DEPTH - 1)) ? '0 : r_wp + 1'b1;
                r_rr <= (w_win == IW'(NMASTERS - 1)) ? '0 : w_win + 1'b1;
            end
            if (w_pop) r_rp <= (r_rp == PW'(DEPTH - 1)) ? '0 : r_rp + 1'b1;
            // Lock holds exactly while a presented request waits for grant; a drop or a grant clears it.
            r_lock <= w_sreq && !s_gnt_i;
            if (w_sreq && !s_gnt_i) r_lock_idx <= w_win;
            r_cnt  <= w_cnt_n;
            r_busy <= (w_cnt_n != '0);
            r_err  <= r_err || w_drop || w_spur;
        end
    end
endmodule
